stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Sequencing controller for the stopwatch. Turns two debounced one-cycle button
//   pulses into start/stop commands for the mspulse generator, and accumulates its
//   msclock ticks into min:sec:ms time registers.
//   Supports run, pause, lap (display freeze) and clear; drives the display path.
// PARAMETERS
//   MS_PER_SEC   1000  ticks per second; ms wraps MS_PER_SEC-1 -> 0
//   SEC_PER_MIN  60    seconds per minute; sec wraps SEC_PER_MIN-1 -> 0
//   MIN_MAX      60    minutes per full span; min wraps MIN_MAX-1 -> 0
// PORTS
//   clk          in   1   system clock, all state on rising edge
//   reset        in   1   asynchronous, active-high; forces reset state below
//   btn_ss       in   1   start/stop button, debounced, one-cycle pulse
//   btn_lr       in   1   lap/clear button, debounced, one-cycle pulse
//   ms_tick      in   1   msclock from mspulse, one-cycle pulse per ms
//   pulse_start  out  1   to mspulse start, one-cycle pulse
//   pulse_stop   out  1   to mspulse stop, one-cycle pulse
//   running      out  1   1 in RUN or LAP
//   lap_active   out  1   1 in LAP (display frozen)
//   wrapped      out  1   sticky; set when time wraps MIN_MAX-1:SEC_PER_MIN-1:MS_PER_SEC-1 -> 0
//   disp_min     out  6   displayed minutes, binary
//   disp_sec     out  6   displayed seconds, binary
//   disp_ms      out  10  displayed milliseconds, binary
// BEHAVIOUR
//   States: IDLE, RUN, PAUSE, LAP. All state/outputs registered, except disp_* mux.
//   Reset (async): state=IDLE, live/lap time=0, pulse_*=0, wrapped=0, running=0, lap_active=0.
//   Transitions (evaluated on edge; btn_ss has priority when both buttons are high, btn_lr ignored):
//     IDLE : btn_ss -> RUN, pulse_start=1 next cycle; btn_lr -> no effect.
//     RUN  : btn_ss -> PAUSE, pulse_stop=1; btn_lr -> LAP, lap regs <= live time.
//     LAP  : btn_ss -> PAUSE, pulse_stop=1 (freeze released); btn_lr -> RUN.
//     PAUSE: btn_ss -> RUN, pulse_start=1; btn_lr -> IDLE, live time=0, wrapped=0.
//   pulse_start/pulse_stop: high exactly one cycle, the cycle after the accepting edge;
//     never both high together.
//   Counting: ms_tick counted only when the current state is RUN or LAP. A tick in the same
//     cycle as a pause command is counted. Ticks in IDLE/PAUSE are ignored.
//   Counted tick -> live time updated on that edge (visible next cycle):
//     ms+1; at MS_PER_SEC-1 ms=0, sec+1; at SEC_PER_MIN-1 sec=0, min+1;
//     at MIN_MAX-1 min=0, wrapped<=1.
//   Lap capture in the same cycle as a tick: captures the pre-increment value.
//   disp_* = lap regs when lap_active, else live regs (combinational mux).
//   Counting continues while in LAP.
//   Reset mid-operation: immediate IDLE, no pulse_stop is issued. mspulse shares the reset.
// TESTING
//   1 reset, then btn_ss -> pulse_start high 1 cycle; running=1; 3 ms_tick -> disp 0:00.003.
//   2 RUN at 0:00.999, 1 tick -> 0:01.000; preload 59:59.999, 1 tick -> 00:00.000, wrapped=1.
//   3 RUN at 0:02.500, btn_lr -> lap_active=1, disp stays 0:02.500 over 40 ticks;
//     btn_lr -> disp 0:02.540.
//   4 RUN, btn_ss with ms_tick same cycle -> tick counted, pulse_stop 1 cycle, PAUSE;
//     further ticks ignored; btn_lr -> disp 0:00.000, wrapped=0.
//   5 btn_ss and btn_lr together in RUN -> PAUSE only, no lap; in IDLE, btn_lr alone -> no change.
//   6 assert reset in LAP mid-count -> all outputs 0 asynchronously; no pulse_* on release.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: turns start/stop and lap/clear pulses into mspulse commands
// and accumulates ms ticks into a min:sec:ms time with a lap freeze register.
module stopwatch_ctrl #(
  parameter int unsigned MS_PER_SEC  = 1000,
  parameter int unsigned SEC_PER_MIN = 60,
  parameter int unsigned MIN_MAX     = 60
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_ss,
  input  logic       i_btn_lr,
  input  logic       i_ms_tick,
  output logic       o_pulse_start,
  output logic       o_pulse_stop,
  output logic       o_running,
  output logic       o_lap_active,
  output logic       o_wrapped,
  output logic [5:0] o_disp_min,
  output logic [5:0] o_disp_sec,
  output logic [9:0] o_disp_ms
);

  localparam logic [9:0] MsLast  = 10'(MS_PER_SEC - 1);
  localparam logic [5:0] SecLast = 6'(SEC_PER_MIN - 1);
  localparam logic [5:0] MinLast = 6'(MIN_MAX - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StLap} state_e;

  state_e     r_state, w_state_nxt;
  logic       r_pulse_start, r_pulse_stop, r_running, r_lap_active, r_wrapped;
  logic [9:0] r_ms, r_lap_ms;
  logic [5:0] r_sec, r_min, r_lap_sec, r_lap_min;
  logic       w_start, w_stop, w_capture, w_clear, w_count;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stop      = 1'b0;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    // btn_ss wins; btn_lr only acts when btn_ss is low
    unique case (r_state)
      StIdle: begin
        if (i_btn_ss) begin
          w_state_nxt = StRun;
          w_start     = 1'b1;
        end
      end
      StRun: begin
        if (i_btn_ss) begin
          w_state_nxt = StPause;
          w_stop      = 1'b1;
        end else if (i_btn_lr) begin
          w_state_nxt = StLap;
          w_capture   = 1'b1;
        end
      end
      StLap: begin
        if (i_btn_ss) begin
          w_state_nxt = StPause;
          w_stop      = 1'b1;
        end else if (i_btn_lr) begin
          w_state_nxt = StRun;
        end
      end
      StPause: begin
        if (i_btn_ss) begin
          w_state_nxt = StRun;
          w_start     = 1'b1;
        end else if (i_btn_lr) begin
          w_state_nxt = StIdle;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_count = i_ms_tick && ((r_state == StRun) || (r_state == StLap));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_pulse_start <= 1'b0;
      r_pulse_stop  <= 1'b0;
      r_running     <= 1'b0;
      r_lap_active  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pulse_start <= w_start;
      r_pulse_stop  <= w_stop;
      r_running     <= (w_state_nxt == StRun) || (w_state_nxt == StLap);
      r_lap_active  <= (w_state_nxt == StLap);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ms      <= '0;
      r_sec     <= '0;
      r_min     <= '0;
      r_wrapped <= 1'b0;
    end else if (w_clear) begin
      r_ms      <= '0;
      r_sec     <= '0;
      r_min     <= '0;
      r_wrapped <= 1'b0;
    end else if (w_count) begin
      if (r_ms == MsLast) begin
        r_ms <= '0;
        if (r_sec == SecLast) begin
          r_sec <= '0;
          if (r_min == MinLast) begin
            r_min     <= '0;
            r_wrapped <= 1'b1;
          end else begin
            r_min <= r_min + 6'd1;
          end
        end else begin
          r_sec <= r_sec + 6'd1;
        end
      end else begin
        r_ms <= r_ms + 10'd1;
      end
    end
  end

  // Capture uses the pre-increment live value when a tick lands on the same edge
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lap_ms  <= '0;
      r_lap_sec <= '0;
      r_lap_min <= '0;
    end else if (w_capture) begin
      r_lap_ms  <= r_ms;
      r_lap_sec <= r_sec;
      r_lap_min <= r_min;
    end
  end

  assign o_pulse_start = r_pulse_start;
  assign o_pulse_stop  = r_pulse_stop;
  assign o_running     = r_running;
  assign o_lap_active  = r_lap_active;
  assign o_wrapped     = r_wrapped;
  assign o_disp_min    = r_lap_active ? r_lap_min : r_min;
  assign o_disp_sec    = r_lap_active ? r_lap_sec : r_sec;
  assign o_disp_ms     = r_lap_active ? r_lap_ms  : r_ms;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: full-size instance for sequencing and carries,
// small-parameter instance for the full-span wrap.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic ss, lr, tk;
  logic pstart, pstop, running, lap, wrapped;
  logic [5:0] dmin, dsec;
  logic [9:0] dms;

  logic w_ss, w_lr, w_tk;
  logic w_pstart, w_pstop, w_running, w_lap, w_wrapped;
  logic [5:0] w_dmin, w_dsec;
  logic [9:0] w_dms;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_btn_ss(ss), .i_btn_lr(lr), .i_ms_tick(tk),
    .o_pulse_start(pstart), .o_pulse_stop(pstop), .o_running(running),
    .o_lap_active(lap), .o_wrapped(wrapped),
    .o_disp_min(dmin), .o_disp_sec(dsec), .o_disp_ms(dms)
  );

  // 10 ms/s, 4 s/min, 3 min span: wraps after 120 ticks
  stopwatch_ctrl #(.MS_PER_SEC(10), .SEC_PER_MIN(4), .MIN_MAX(3)) dut_w (
    .i_clk(clk), .i_reset(reset), .i_btn_ss(w_ss), .i_btn_lr(w_lr), .i_ms_tick(w_tk),
    .o_pulse_start(w_pstart), .o_pulse_stop(w_pstop), .o_running(w_running),
    .o_lap_active(w_lap), .o_wrapped(w_wrapped),
    .o_disp_min(w_dmin), .o_disp_sec(w_dsec), .o_disp_ms(w_dms)
  );

  function automatic logic [21:0] t(input int m, input int s, input int ms);
    t = {6'(m), 6'(s), 10'(ms)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs applied 1 time unit after an edge, held through the next edge, sampled #1 after it
  task automatic cyc(input logic b_ss, input logic b_lr, input logic b_tk);
    ss = b_ss; lr = b_lr; tk = b_tk;
    @(posedge clk); #1;
    ss = 1'b0; lr = 1'b0; tk = 1'b0;
  endtask

  task automatic wcyc(input logic b_ss, input logic b_lr, input logic b_tk);
    w_ss = b_ss; w_lr = b_lr; w_tk = b_tk;
    @(posedge clk); #1;
    w_ss = 1'b0; w_lr = 1'b0; w_tk = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ss = 1'b0; lr = 1'b0; tk = 1'b0;
    w_ss = 1'b0; w_lr = 1'b0; w_tk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_lap", 32'(lap), 32'd0);
    chk("rst_pulses", 32'({pstart, pstop}), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    chk("rst_disp", 32'({dmin, dsec, dms}), 32'(t(0, 0, 0)));
    reset = 1'b0;

    // 1: start, three ticks
    cyc(1, 0, 0);
    chk("t1_pstart", 32'(pstart), 32'd1);
    chk("t1_pstop", 32'(pstop), 32'd0);
    chk("t1_running", 32'(running), 32'd1);
    cyc(0, 0, 1);
    chk("t1_pstart_1cyc", 32'(pstart), 32'd0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("t1_disp3", 32'({dmin, dsec, dms}), 32'(t(0, 0, 3)));

    // 2: ms -> sec carry
    for (int i = 0; i < 996; i++) cyc(0, 0, 1);
    chk("t2_999", 32'({dmin, dsec, dms}), 32'(t(0, 0, 999)));
    cyc(0, 0, 1);
    chk("t2_carry", 32'({dmin, dsec, dms}), 32'(t(0, 1, 0)));

    // 3: lap freeze, capture on a tick edge takes the pre-increment value
    for (int i = 0; i < 1500; i++) cyc(0, 0, 1);
    chk("t3_2500", 32'({dmin, dsec, dms}), 32'(t(0, 2, 500)));
    cyc(0, 1, 1);
    chk("t3_lap_on", 32'(lap), 32'd1);
    chk("t3_lap_running", 32'(running), 32'd1);
    chk("t3_lap_disp", 32'({dmin, dsec, dms}), 32'(t(0, 2, 500)));
    for (int i = 0; i < 39; i++) cyc(0, 0, 1);
    chk("t3_frozen", 32'({dmin, dsec, dms}), 32'(t(0, 2, 500)));
    cyc(0, 1, 0);
    chk("t3_lap_off", 32'(lap), 32'd0);
    chk("t3_release", 32'({dmin, dsec, dms}), 32'(t(0, 2, 540)));

    // 4: pause with simultaneous tick, then clear
    cyc(1, 0, 1);
    chk("t4_pstop", 32'(pstop), 32'd1);
    chk("t4_pstart", 32'(pstart), 32'd0);
    chk("t4_running", 32'(running), 32'd0);
    chk("t4_tick_counted", 32'({dmin, dsec, dms}), 32'(t(0, 2, 541)));
    cyc(0, 0, 1);
    chk("t4_pstop_1cyc", 32'(pstop), 32'd0);
    cyc(0, 0, 1);
    chk("t4_ignored", 32'({dmin, dsec, dms}), 32'(t(0, 2, 541)));
    cyc(0, 1, 0);
    chk("t4_clear", 32'({dmin, dsec, dms}), 32'(t(0, 0, 0)));
    chk("t4_clear_wrapped", 32'(wrapped), 32'd0);
    chk("t4_idle", 32'(running), 32'd0);

    // 5: btn_lr in IDLE is a no-op; both buttons in RUN act as pause only
    cyc(0, 1, 1);
    chk("t5_idle_lr", 32'({running, lap, pstart, pstop}), 32'd0);
    chk("t5_idle_disp", 32'({dmin, dsec, dms}), 32'(t(0, 0, 0)));
    cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1);
    chk("t5_run5", 32'({dmin, dsec, dms}), 32'(t(0, 0, 5)));
    cyc(1, 1, 0);
    chk("t5_both_pstop", 32'(pstop), 32'd1);
    chk("t5_both_nolap", 32'({running, lap}), 32'd0);
    cyc(0, 0, 1);
    chk("t5_paused", 32'({dmin, dsec, dms}), 32'(t(0, 0, 5)));

    // 6: async reset while in LAP and counting
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    cyc(0, 1, 0);
    chk("t6_in_lap", 32'({running, lap}), 32'b11);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    tk = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("t6_async_flags", 32'({running, lap, pstart, pstop, wrapped}), 32'd0);
    chk("t6_async_disp", 32'({dmin, dsec, dms}), 32'(t(0, 0, 0)));
    @(posedge clk); #3;
    reset = 1'b0;
    tk = 1'b0;
    cyc(0, 0, 1);
    chk("t6_no_pulse", 32'({pstart, pstop}), 32'd0);
    cyc(0, 0, 1);
    chk("t6_no_pulse2", 32'({pstart, pstop, running}), 32'd0);
    chk("t6_idle_disp", 32'({dmin, dsec, dms}), 32'(t(0, 0, 0)));

    // Full-span wrap on the small instance
    wcyc(1, 0, 0);
    for (int i = 0; i < 119; i++) wcyc(0, 0, 1);
    chk("w_last", 32'({w_dmin, w_dsec, w_dms}), 32'(t(2, 3, 9)));
    chk("w_not_yet", 32'(w_wrapped), 32'd0);
    wcyc(0, 0, 1);
    chk("w_zero", 32'({w_dmin, w_dsec, w_dms}), 32'(t(0, 0, 0)));
    chk("w_wrapped", 32'(w_wrapped), 32'd1);
    wcyc(0, 0, 1);
    chk("w_sticky", 32'(w_wrapped), 32'd1);
    chk("w_after", 32'({w_dmin, w_dsec, w_dms}), 32'(t(0, 0, 1)));
    wcyc(1, 0, 0);
    wcyc(0, 1, 0);
    chk("w_clear", 32'(w_wrapped), 32'd0);
    chk("w_clear_disp", 32'({w_dmin, w_dsec, w_dms}), 32'(t(0, 0, 0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
